// File: rtl/usb_pkg.sv
// Shared USB sizing constants used by the data buffer, usb_tx, usb_rx and the AHB slave.
package usb_pkg;

  localparam int USB_BUFFER_DEPTH = 64;
  localparam int USB_OCCUPANCY_W  = 7;
  localparam int USB_BYTE_W       = 8;

  typedef logic [USB_BYTE_W-1:0] usb_byte_t;

endpackage

// File: rtl/usb_fifo_ctrl.sv
// FIFO bookkeeping: read/write pointers, occupancy count, sticky error flag and
// arbitration between the two push sources and the two pop sources.
module usb_fifo_ctrl #(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       clear,
  input  logic                       push_tx,
  input  logic                       push_rx,
  input  logic                       pop_tx,
  input  logic                       pop_rx,
  output logic                       wr_en,
  output logic                       wr_sel_tx,
  output logic [$clog2(DEPTH)-1:0]   wptr,
  output logic [$clog2(DEPTH)-1:0]   rptr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wptr_reg, wptr_next;
  logic [PTR_W-1:0] rptr_reg, rptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             error_reg, error_next;

  logic push, pop, empty, full, do_push, do_pop, err_evt;

  assign push  = push_tx | push_rx;
  assign pop   = pop_tx | pop_rx;
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_FULL);

  // A full buffer still accepts a push when a pop frees the head slot in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);
  assign err_evt = (push_tx & push_rx) | (push & full & ~pop) | (pop & empty);

  always_comb begin
    wptr_next  = wptr_reg;
    rptr_next  = rptr_reg;
    count_next = count_reg;
    error_next = error_reg | err_evt;
    if (do_push) wptr_next = wptr_reg + PTR_ONE;
    if (do_pop)  rptr_next = rptr_reg + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
    if (clear) begin
      wptr_next  = '0;
      rptr_next  = '0;
      count_next = '0;
      error_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      wptr_reg  <= wptr_next;
      rptr_reg  <= rptr_next;
      count_reg <= count_next;
      error_reg <= error_next;
    end
  end

  assign wr_en     = do_push & ~clear;
  assign wr_sel_tx = push_tx;
  assign wptr      = wptr_reg;
  assign rptr      = rptr_reg;
  assign count     = count_reg;
  assign error     = error_reg;

endmodule

// File: rtl/usb_data_buffer.sv
// Shared 64-byte first-word-fall-through endpoint FIFO between AHB, usb_rx and usb_tx.
// Head byte is a register-only mux, so there is no input-to-output combinational path.
module usb_data_buffer
  import usb_pkg::*;
#(
  parameter int DEPTH = USB_BUFFER_DEPTH,
  parameter int WIDTH = USB_BYTE_W
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     Clear,
  input  logic                     Store_TX_Data,
  input  logic [WIDTH-1:0]         TX_Data,
  input  logic                     Store_RX_Packet_Data,
  input  logic [WIDTH-1:0]         RX_Packet_Data,
  input  logic                     Get_TX_Packet_Data,
  input  logic                     Get_RX_Data,
  output logic [WIDTH-1:0]         TX_Packet_Data,
  output logic [WIDTH-1:0]         RX_Data,
  output logic [$clog2(DEPTH):0]   Buffer_Occupancy,
  output logic                     Buffer_Error
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en, wr_sel_tx;
  logic [PTR_W-1:0] wptr, rptr;
  logic [PTR_W:0]   count;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] head;

  usb_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (Clear),
    .push_tx   (Store_TX_Data),
    .push_rx   (Store_RX_Packet_Data),
    .pop_tx    (Get_TX_Packet_Data),
    .pop_rx    (Get_RX_Data),
    .wr_en     (wr_en),
    .wr_sel_tx (wr_sel_tx),
    .wptr      (wptr),
    .rptr      (rptr),
    .count     (count),
    .error     (Buffer_Error)
  );

  // On a push collision the AHB byte wins and the usb_rx byte is dropped.
  assign wr_data = wr_sel_tx ? TX_Data : RX_Packet_Data;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wr_data;
  end

  assign head             = (count != '0) ? mem[rptr] : '0;
  assign TX_Packet_Data   = head;
  assign RX_Data          = head;
  assign Buffer_Occupancy = count;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Scoreboard bench for usb_data_buffer: a byte queue models the FIFO and is
// compared against the DUT head on every pop and against occupancy/error after each cycle.
module tb_usb_data_buffer;

  logic       tb_clk = 1'b0;
  logic       n_rst;
  logic       Clear;
  logic       Store_TX_Data;
  logic [7:0] TX_Data;
  logic       Store_RX_Packet_Data;
  logic [7:0] RX_Packet_Data;
  logic       Get_TX_Packet_Data;
  logic       Get_RX_Data;
  logic [7:0] TX_Packet_Data;
  logic [7:0] RX_Data;
  logic [6:0] Buffer_Occupancy;
  logic       Buffer_Error;

  logic [7:0] exp_q [$];
  logic       exp_err;
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 tb_clk = ~tb_clk;

  usb_data_buffer dut (
    .clk                  (tb_clk),
    .n_rst                (n_rst),
    .Clear                (Clear),
    .Store_TX_Data        (Store_TX_Data),
    .TX_Data              (TX_Data),
    .Store_RX_Packet_Data (Store_RX_Packet_Data),
    .RX_Packet_Data       (RX_Packet_Data),
    .Get_TX_Packet_Data   (Get_TX_Packet_Data),
    .Get_RX_Data          (Get_RX_Data),
    .TX_Packet_Data       (TX_Packet_Data),
    .RX_Data              (RX_Data),
    .Buffer_Occupancy     (Buffer_Occupancy),
    .Buffer_Error         (Buffer_Error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] exp_head();
    return (exp_q.size() != 0) ? exp_q[0] : 8'h00;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_occ"}, 32'(Buffer_Occupancy), 32'(exp_q.size()));
    check({tag, "_err"}, 32'(Buffer_Error), 32'(exp_err));
    check({tag, "_txhead"}, 32'(TX_Packet_Data), 32'(exp_head()));
    check({tag, "_rxhead"}, 32'(RX_Data), 32'(exp_head()));
  endtask

  task automatic idle_inputs();
    Clear = 1'b0; Store_TX_Data = 1'b0; TX_Data = 8'h00;
    Store_RX_Packet_Data = 1'b0; RX_Packet_Data = 8'h00;
    Get_TX_Packet_Data = 1'b0; Get_RX_Data = 1'b0;
  endtask

  // One clock of stimulus; the scoreboard is updated as the stimulus is driven.
  task automatic op(input logic stx, input logic [7:0] txd, input logic srx, input logic [7:0] rxd,
                    input logic gtx, input logic grx, input string tag);
    int  sz;
    bit  push_any, pop_any;
    push_any = stx | srx;
    pop_any  = gtx | grx;
    sz       = exp_q.size();
    if (pop_any && sz != 0) check({tag, "_pop"}, 32'(TX_Packet_Data), 32'(exp_q[0]));
    if (stx && srx) exp_err = 1'b1;
    if (pop_any) begin
      if (sz == 0) exp_err = 1'b1;
      else void'(exp_q.pop_front());
    end
    if (push_any) begin
      if (sz < 64 || pop_any) exp_q.push_back(stx ? txd : rxd);
      else exp_err = 1'b1;
    end
    Store_TX_Data = stx; TX_Data = txd;
    Store_RX_Packet_Data = srx; RX_Packet_Data = rxd;
    Get_TX_Packet_Data = gtx; Get_RX_Data = grx;
    @(posedge tb_clk);
    #1;
    idle_inputs();
  endtask

  task automatic push_tx(input logic [7:0] b, input string tag);
    op(1'b1, b, 1'b0, 8'h00, 1'b0, 1'b0, tag);
  endtask

  task automatic pop_tx(input string tag);
    op(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, tag);
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    exp_q.delete();
    exp_err = 1'b0;
    @(posedge tb_clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    exp_err = 1'b0;
    n_rst = 1'b0;
    repeat (3) @(posedge tb_clk);
    #1;
    check_state("reset");
    n_rst = 1'b1;
    @(posedge tb_clk);
    #1;

    push_tx(8'hA5, "first");
    check_state("first_push");
    do_clear();

    for (int i = 0; i < 64; i++) push_tx(8'(i), "fill");
    check_state("full64");
    for (int i = 0; i < 64; i++) pop_tx("drain");
    check_state("drained");

    for (int i = 0; i < 64; i++) push_tx(8'(8'h40 + i), "fill2");
    push_tx(8'hEE, "overflow");
    check_state("overflow");
    op(1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b0, "full_pushpop");
    check_state("full_pushpop");
    for (int i = 0; i < 64; i++) pop_tx("drain2");
    check_state("drained2");
    do_clear();

    for (int i = 0; i < 40; i++) push_tx(8'(i), "wrapfill");
    for (int i = 0; i < 40; i++) pop_tx("wrapdrain");
    for (int i = 0; i < 40; i++) push_tx(8'(8'h80 + i), "wrapfill2");
    check_state("wrap_full40");
    for (int i = 0; i < 40; i++) pop_tx("wrapread");
    check_state("wrap_done");

    op(1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, "rxpush");
    op(1'b0, 8'h00, 1'b1, 8'h3D, 1'b0, 1'b0, "rxpush");
    op(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, "rxpop");
    op(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, "bothpop");
    check_state("rx_path");

    op(1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, "collide");
    check_state("collide");
    do_clear();
    check_state("cleared");

    op(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, "underflow");
    check_state("underflow");
    do_clear();

    push_tx(8'h5A, "pre_rst");
    push_tx(8'h5B, "pre_rst");
    Store_TX_Data = 1'b1; TX_Data = 8'h5C;
    #2;
    n_rst = 1'b0;
    exp_q.delete();
    exp_err = 1'b0;
    #1;
    check_state("async_rst");
    idle_inputs();
    @(posedge tb_clk);
    #1;
    n_rst = 1'b1;
    check_state("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/usb_data_buffer.md
# usb_data_buffer

Endpoint data FIFO sitting directly upstream of `usb_tx`: supplies `TX_Packet_Data` and `Buffer_Occupancy` and pops one byte per `Get_TX_Packet_Data` strobe. Also serves the AHB-Lite slave (TX-data writes, RX-data reads) and `usb_rx` (RX-data writes), so one 64-byte store holds whichever packet payload is in flight. First-word-fall-through: the head byte is always presented without a read latency.

## Interface
- `DEPTH`, 64, byte capacity (power of two)
- `WIDTH`, 8, data bits per entry
- `clk` in 1: system clock, all state on rising edge
- `n_rst` in 1: asynchronous, active-low reset
- `Clear` in 1: synchronous flush (from AHB control register)
- `Store_TX_Data` in 1: AHB push strobe
- `TX_Data` in 8: AHB push byte
- `Store_RX_Packet_Data` in 1: `usb_rx` push strobe
- `RX_Packet_Data` in 8: `usb_rx` push byte
- `Get_TX_Packet_Data` in 1: `usb_tx` pop strobe
- `Get_RX_Data` in 1: AHB pop strobe
- `TX_Packet_Data` out 8: head byte to `usb_tx`
- `RX_Data` out 8: head byte to AHB (same value as `TX_Packet_Data`)
- `Buffer_Occupancy` out 7: stored byte count, 0..64
- `Buffer_Error` out 1: sticky overflow/underflow/collision flag

## Operation
- Storage: DEPTH x WIDTH flop array, 6-bit write pointer, 6-bit read pointer, 7-bit count; pointers wrap 63 -> 0 by natural overflow.
- Push = `Store_TX_Data | Store_RX_Packet_Data`. Both high same cycle: `TX_Data` written, RX byte dropped, `Buffer_Error` set.
- Pop = `Get_TX_Packet_Data | Get_RX_Data`; both high same cycle pops exactly one byte, no error.
- Push when full and no pop: ignored, `Buffer_Error` set. Push + pop when full: both performed, count stays 64.
- Pop when empty: ignored, `Buffer_Error` set. Push + pop when empty: push performed, pop ignored, error set.
- Push + pop otherwise: both performed, count unchanged.
- Head outputs = `mem[rptr]` when count != 0, else 8'h00.
- `Clear`: pointers, count, `Buffer_Error` to 0 next edge; overrides any same-cycle push/pop; array contents not cleared.
- `Buffer_Error` cleared only by `Clear` or reset.

## Timing
- Reset: `Buffer_Occupancy`=0, `Buffer_Error`=0, `TX_Packet_Data`=`RX_Data`=8'h00; array contents undefined (never visible, since count=0).
- Push at edge N: byte stored, count+1 visible after edge N; if buffer was empty, head shows the byte after edge N (1-cycle write-to-read latency).
- Pop at edge N: next byte (or 8'h00 if now empty) at head after edge N; `usb_tx` samples head in the same cycle it asserts `Get_TX_Packet_Data`.
- All outputs glitch-free functions of registers only; no combinational path from any input to any output.
- Reset asserted mid-packet: immediate return to reset values regardless of clock.

## Structure
- `usb_pkg`: `USB_BUFFER_DEPTH`=64, `USB_OCCUPANCY_W`=7, `USB_BYTE_W`=8, shared with `usb_tx`/`usb_rx`/AHB slave.
- One sub-module: `usb_fifo_ctrl` (pointers, count, error flag, push/pop arbitration); array and head mux in the top.

## Test plan
- Reset, then push 0xA5 via `Store_TX_Data` -> next cycle occupancy=1, both heads=0xA5, error=0.
- Push 64 bytes 0x00..0x3F, pop all via `Get_TX_Packet_Data` -> occupancy 64 then 0, heads 0x00..0x3F in order, final head 0x00.
- Full buffer, 65th push -> occupancy stays 64, error=1; then push+pop same cycle -> occupancy 64, head advances, new byte lands at tail.
- Pointer wrap: push 40, pop 40, push 40 values 0x80..0xA7 -> read back 0x80..0xA7 in order across index 63->0.
- Simultaneous `Store_TX_Data`=0x11 and `Store_RX_Packet_Data`=0x22 on empty buffer -> occupancy 1, head 0x11, error=1; `Clear` -> occupancy 0, error 0, head 0x00.
- Pop on empty with both pop strobes -> occupancy 0, error=1; async `n_rst` low mid-transfer -> all outputs to reset values before next edge.
